// File: rtl/cluster_periph_rr_arbiter.sv
// Round-robin arbiter sharing one peripheral slave port among NumCores core data ports.
// One transaction in flight; request fields are registered at arbitration time.
module cluster_periph_rr_lane (
  input  logic sel,
  input  logic gnt_ev,
  input  logic rsp_ev,
  output logic gnt,
  output logic r_valid
);
  assign gnt     = sel & gnt_ev;
  assign r_valid = sel & rsp_ev;
endmodule

module cluster_periph_rr_arbiter #(
  parameter int unsigned           NumCores      = 8,
  parameter int unsigned           AddrWidth     = 32,
  parameter int unsigned           DataWidth     = 32,
  parameter int unsigned           TimeoutCycles = 255,
  parameter logic [DataWidth-1:0]  ErrData       = 32'hBADACCE5
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumCores-1:0]             core_req_i,
  input  logic [NumCores*AddrWidth-1:0]   core_add_i,
  input  logic [NumCores-1:0]             core_we_i,
  input  logic [NumCores*DataWidth-1:0]   core_data_i,
  input  logic [NumCores*DataWidth/8-1:0] core_be_i,
  output logic [NumCores-1:0]             core_gnt_o,
  output logic [NumCores-1:0]             core_r_valid_o,
  output logic [DataWidth-1:0]            core_r_data_o,
  output logic                            slv_req_o,
  output logic [AddrWidth-1:0]            slv_add_o,
  output logic                            slv_we_o,
  output logic [DataWidth-1:0]            slv_wdata_o,
  output logic [DataWidth/8-1:0]          slv_be_o,
  input  logic                            slv_gnt_i,
  input  logic                            slv_r_valid_i,
  input  logic [DataWidth-1:0]            slv_r_data_i,
  output logic                            timeout_o,
  output logic                            spurious_o,
  output logic                            busy_o
);
  localparam int unsigned BeWidth = DataWidth / 8;
  localparam int unsigned IdxW    = (NumCores > 1) ? $clog2(NumCores) : 1;
  localparam int unsigned CntW    = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam int unsigned TmoLast = (TimeoutCycles == 0) ? 0 : TimeoutCycles - 1;

  typedef struct packed {
    logic [AddrWidth-1:0] add;
    logic                 we;
    logic [DataWidth-1:0] wdata;
    logic [BeWidth-1:0]   be;
  } slv_fields_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_e;

  state_e         state;
  logic [IdxW-1:0] ptr, winner, arb_idx, ptr_nxt;
  logic [CntW-1:0] cnt;
  slv_fields_t     lat, arb_fields;
  logic            spur_q;
  logic            tmo_hit, gnt_ev, rsp_ev, tmo_fire, rsp_real;

  // First requester at or after ptr, wrapping; fields muxed alongside the index.
  always_comb begin
    int unsigned cand;
    logic        found;
    cand       = 0;
    found      = 1'b0;
    arb_idx    = '0;
    arb_fields = '0;
    for (int unsigned i = 0; i < NumCores; i++) begin
      cand = (int'(ptr) + i) % NumCores;
      if (!found && core_req_i[IdxW'(cand)]) begin
        found            = 1'b1;
        arb_idx          = IdxW'(cand);
        arb_fields.add   = core_add_i[cand*AddrWidth +: AddrWidth];
        arb_fields.we    = core_we_i[IdxW'(cand)];
        arb_fields.wdata = core_data_i[cand*DataWidth +: DataWidth];
        arb_fields.be    = core_be_i[cand*BeWidth +: BeWidth];
      end
    end
  end

  assign ptr_nxt  = (winner == IdxW'(NumCores-1)) ? '0 : winner + 1'b1;
  assign tmo_hit  = (TimeoutCycles != 0) && (cnt == CntW'(TmoLast));
  assign gnt_ev   = (state == ISSUE) && slv_gnt_i;
  assign rsp_real = (state == WAIT_RSP) && slv_r_valid_i;
  assign tmo_fire = (state == WAIT_RSP) && !slv_r_valid_i && tmo_hit;
  assign rsp_ev   = rsp_real || tmo_fire;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      ptr    <= '0;
      winner <= '0;
      cnt    <= '0;
      lat    <= '0;
      spur_q <= 1'b0;
    end else begin
      spur_q <= slv_r_valid_i && (state != WAIT_RSP);
      case (state)
        IDLE: if (|core_req_i) begin
          winner <= arb_idx;
          lat    <= arb_fields;
          state  <= ISSUE;
        end
        ISSUE: if (slv_gnt_i) begin
          cnt   <= '0;
          state <= WAIT_RSP;
        end
        WAIT_RSP: if (rsp_ev) begin
          ptr   <= ptr_nxt;
          state <= IDLE;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NumCores; g++) begin : g_lane
    cluster_periph_rr_lane u_lane (
      .sel     (winner == IdxW'(g)),
      .gnt_ev  (gnt_ev),
      .rsp_ev  (rsp_ev),
      .gnt     (core_gnt_o[g]),
      .r_valid (core_r_valid_o[g])
    );
  end

  assign core_r_data_o = rsp_real ? slv_r_data_i : (tmo_fire ? ErrData : '0);
  assign slv_req_o     = (state == ISSUE);
  assign slv_add_o     = lat.add;
  assign slv_we_o      = lat.we;
  assign slv_wdata_o   = lat.wdata;
  assign slv_be_o      = lat.be;
  assign timeout_o     = tmo_fire;
  assign spurious_o    = spur_q;
  assign busy_o        = (state != IDLE);
endmodule
